// File: rtl/aes_inv_key_schedule.sv
// Reverse AES-128 key schedule: loads the round-10 key and emits round keys 10 down to 0 over a valid/ready handshake.
// Optional full expanded-key capture port is enabled with `define AES_INV_KEY_FULL_OUT_EN.
module aes_inv_key_schedule #(
  parameter int NR = 10  // AES-128 only; other values are not supported
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [127:0]   last_key_in,
  input  logic           key_ready,
  output logic           key_valid,
  output logic [127:0]   round_key_out,
  output logic [3:0]     round_idx,
  output logic           busy,
  output logic           done
`ifdef AES_INV_KEY_FULL_OUT_EN
  ,
  output logic [1407:0]  full_expanded_key,
  output logic           full_ready
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EMIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] LAST_IDX = 4'(NR);

  // Forward S-box, byte 0x00 in the most significant position.
  localparam logic [2047:0] SBOX_FLAT = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_FLAT[8 * (255 - int'(b)) +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  logic [1:0]   state;
  logic [127:0] cur_key;

  logic [31:0]  n0, n1, n2, n3;
  logic [31:0]  p0, p1, p2, p3;
  logic [31:0]  rot_p3;
  logic [31:0]  sub_p3;
  logic [127:0] prev_key;
  logic         handshake;

  // Undo one expansion step: words 1..3 are pairwise XORs, word 0 needs the recovered word 3.
  assign n0 = cur_key[31:0];
  assign n1 = cur_key[63:32];
  assign n2 = cur_key[95:64];
  assign n3 = cur_key[127:96];

  assign p3 = n3 ^ n2;
  assign p2 = n2 ^ n1;
  assign p1 = n1 ^ n0;

  assign rot_p3 = {p3[23:0], p3[31:24]};
  assign sub_p3 = {sbox(rot_p3[31:24]), sbox(rot_p3[23:16]),
                   sbox(rot_p3[15:8]),  sbox(rot_p3[7:0])};

  assign p0       = n0 ^ sub_p3 ^ {rcon(round_idx), 24'h000000};
  assign prev_key = {p3, p2, p1, p0};

  assign round_key_out = cur_key;
  assign handshake     = (state == S_EMIT) && key_ready;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      cur_key   <= '0;
      round_idx <= '0;
      key_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            cur_key   <= last_key_in;
            round_idx <= LAST_IDX;
            key_valid <= 1'b1;
            busy      <= 1'b1;
            state     <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (key_ready) begin
            if (round_idx != 4'd0) begin
              cur_key   <= prev_key;
              round_idx <= round_idx - 4'd1;
            end else begin
              key_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              state     <= S_DONE;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef AES_INV_KEY_FULL_OUT_EN
  // NOTE: this key bank is a plain register array, so it takes the async reset like any other state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full_expanded_key <= '0;
      full_ready        <= 1'b0;
    end else if ((state == S_IDLE) && start) begin
      full_expanded_key <= '0;
      full_ready        <= 1'b0;
    end else if (handshake) begin
      full_expanded_key[128 * int'(round_idx) +: 128] <= cur_key;
      if (round_idx == 4'd0) full_ready <= 1'b1;
    end
  end
`endif

endmodule

// File: doc/aes_inv_key_schedule.md
Name: aes_inv_key_schedule

Overview:
- Reverse-direction AES-128 key schedule: loads the round-10 key and walks the schedule backwards, emitting round keys 10, 9, …, 0, one per handshake.
- Feeds the decryption datapath (inverse cipher), which consumes round keys in reverse order, without storing the full 1408-bit expanded key.
- Word/byte packing matches expand_key_top: word w[4r+j] sits at bits [32j+31:32j] of round key r; the first byte of each word is in bits [31:24].

Parameters:
- NR, 10, number of rounds; fixed at 10 for AES-128; any other value is unsupported.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-low (0 = reset)
- start  in  1  single-cycle request; latches last_key_in when idle
- last_key_in  in  128  round-10 key, packed as above
- key_ready  in  1  consumer accepts round_key_out this cycle
- key_valid  out  1  round_key_out / round_idx are valid
- round_key_out  out  128  current round key
- round_idx  out  4  round number of round_key_out (10 down to 0)
- busy  out  1  high from the accepted start until done
- done  out  1  one-cycle pulse after round 0 is accepted

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; key_valid=0, round_key_out=0, round_idx=0, busy=0, done=0. Reset mid-sequence aborts immediately; no further keys are emitted.
- FSM states: IDLE, EMIT, DONE.
- IDLE: on start=1, cur_key<=last_key_in, round_idx<=10, state<=EMIT. key_valid=1 and busy=1 from the next cycle (latency 1).
- start while not IDLE is ignored.
- EMIT: round_key_out=cur_key and key_valid=1.
  - key_valid && !key_ready: all outputs hold stable (backpressure).
  - Handshake with round_idx>0: cur_key<=prev_key(cur_key, Rcon[round_idx]); round_idx decrements; key_valid stays 1.
  - With key_ready tied high, the 11 keys appear on 11 consecutive cycles.
  - Handshake with round_idx==0: state<=DONE; key_valid<=0.
- DONE: done=1 for exactly one cycle, busy=0; state<=IDLE. start is not accepted in DONE.
- prev_key, purely combinational in one cycle. Given next-round words n0..n3, produce p0..p3:
  - p3=n3^n2
  - p2=n2^n1
  - p1=n1^n0
  - p0=n0^SubWord(RotWord(p3))^{Rcon,24'h0}
- RotWord: left-rotate by one byte, i.e. {b1,b2,b3,b0}.
- SubWord: AES forward S-box on each byte (256-entry combinational ROM, 4 instances).
- Rcon[1..10]: 01,02,04,08,10,20,40,80,1b,36. Producing round r uses Rcon[r+1].
- round_idx is never below 0; no wrap-around.

Optional Feature:
- Macro: AES_INV_KEY_FULL_OUT_EN.
- When defined:
  - Extra output full_expanded_key [1407:0]: each accepted key is written to bits [128*round_idx+127:128*round_idx].
  - Extra output full_ready: set in the DONE cycle and held until the next accepted start or reset.
  - The bus format is identical to the expand_key_top output.
  - The register clears to 0 on reset and on an accepted start.
- When not defined: neither port exists and no 1408-bit storage is inferred.

Test Plan:
- FIPS-197 C.1, key_ready=1:
  - Stimulus: start with last_key_in=128'h4d2b30c5f307a78be3944a1713111d7f.
  - Keys: idx10 equals the input; idx9=128'hbe2c974e1093ed9cf0855768549932d1; idx0=128'h0c0d0e0f08090a0b0405060700010203.
  - Timing: 11 consecutive valid cycles, then a done pulse.
- FIPS-197 A.1:
  - Stimulus: last_key_in=128'hb6630ca6e13f0cc8c9ee2589d014f9a8.
  - Response: idx0=128'h09cf4f3cabf7158828aed2a62b7e1516.
- Backpressure:
  - Stimulus: key_ready toggled pseudo-randomly during the C.1 run.
  - Response: outputs stable while stalled; the same 11-key sequence; exactly 11 handshakes.
- start while busy:
  - Stimulus: start pulsed at idx 6 with a different key.
  - Response: ignored; the original sequence completes unchanged.
- Reset mid-sequence:
  - Stimulus: rst=0 at idx 4, asynchronously between edges.
  - Response: key_valid/busy drop immediately, all outputs are 0; a subsequent start runs a full correct sequence.
- With AES_INV_KEY_FULL_OUT_EN, C.1 run:
  - Response: full_ready=1 after done; full_expanded_key[127:0]=128'h0c0d0e0f08090a0b0405060700010203 and [1407:1280]=last_key_in.
